// File: rtl/bcd_alu_seq.sv
// Multi-cycle packed-BCD add/sub/mul/div with binary and BCD results; latency DIGITS+1+2*BW+1 (add/sub), DIGITS+3*BW+1 (mul/div).
// No backpressure: start is taken only in IDLE, ignored while busy; done is a one-cycle pulse with results held until the next done.
module bcd_alu_seq #(
  parameter int DIGITS = 3,
  parameter int BW     = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [3:0]            sym,
  input  logic [4*DIGITS-1:0]   num_reg1,
  input  logic [4*DIGITS-1:0]   num_reg2,
  output logic                  busy,
  output logic                  done,
  output logic [2*BW-1:0]       result_bin,
  output logic [8*DIGITS-1:0]   result_bcd,
  output logic                  neg,
  output logic                  err
);

  localparam int DW   = 4 * DIGITS;
  localparam int RW   = 2 * BW;
  localparam int BCDW = 8 * DIGITS;
  localparam int CW   = $clog2(RW + 1);

  typedef enum logic [2:0] {S_IDLE, S_CONV, S_EXEC, S_B2D, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [DW-1:0]     bcd1_q, bcd1_d, bcd2_q, bcd2_d;
  logic [3:0]        sym_q, sym_d;
  logic [BW-1:0]     op1_q, op1_d, op2_q, op2_d, rem_q, rem_d;
  logic [RW-1:0]     res_q, res_d, sh_q, sh_d, rbin_q, rbin_d;
  logic [BCDW-1:0]   bcdw_q, bcdw_d, rbcd_q, rbcd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              negw_q, negw_d, errw_q, errw_d, rneg_q, rneg_d, rerr_q, rerr_d;

  logic [3:0]        d1, d2;
  logic [BW:0]       rem_t;
  logic [BCDW-1:0]   adj;

  always_comb begin
    state_d = state_q;
    bcd1_d  = bcd1_q;
    bcd2_d  = bcd2_q;
    sym_d   = sym_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    rem_d   = rem_q;
    res_d   = res_q;
    sh_d    = sh_q;
    bcdw_d  = bcdw_q;
    cnt_d   = cnt_q;
    negw_d  = negw_q;
    errw_d  = errw_q;
    rbin_d  = rbin_q;
    rbcd_d  = rbcd_q;
    rneg_d  = rneg_q;
    rerr_d  = rerr_q;
    d1      = bcd1_q[DW-1 -: 4];
    d2      = bcd2_q[DW-1 -: 4];
    rem_t   = {rem_q, op1_q[BW-1]};
    adj     = bcdw_q;

    case (state_q)
      S_IDLE: begin
        if (start && (sym inside {4'ha, 4'hb, 4'hc, 4'hd})) begin
          bcd1_d  = num_reg1;
          bcd2_d  = num_reg2;
          sym_d   = sym;
          op1_d   = '0;
          op2_d   = '0;
          negw_d  = 1'b0;
          errw_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        op1_d  = (op1_q << 3) + (op1_q << 1) + BW'(d1);
        op2_d  = (op2_q << 3) + (op2_q << 1) + BW'(d2);
        bcd1_d = bcd1_q << 4;
        bcd2_d = bcd2_q << 4;
        if (d1 > 4'd9 || d2 > 4'd9) errw_d = 1'b1;
        if (cnt_q == CW'(DIGITS - 1)) begin
          cnt_d   = '0;
          res_d   = '0;
          rem_d   = '0;
          state_d = errw_d ? S_DONE : S_EXEC;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_EXEC: begin
        case (sym_q)
          4'ha: begin
            res_d   = RW'(op1_q) + RW'(op2_q);
            state_d = S_B2D;
          end
          4'hb: begin
            if (op1_q >= op2_q) begin
              res_d = RW'(op1_q - op2_q);
            end else begin
              res_d  = RW'(op2_q - op1_q);
              negw_d = 1'b1;
            end
            state_d = S_B2D;
          end
          4'hc: begin
            if (op2_q[0]) res_d = res_q + (RW'(op1_q) << cnt_q);
            op2_d = op2_q >> 1;
          end
          default: begin
            if (cnt_q == '0 && op2_q == '0) begin
              errw_d  = 1'b1;
              res_d   = '0;
              state_d = S_DONE;
            end else begin
              // Restoring step: quotient bits enter res from the LSB, MSB first.
              op1_d = op1_q << 1;
              if (rem_t >= {1'b0, op2_q}) begin
                rem_d = BW'(rem_t - {1'b0, op2_q});
                res_d = {res_q[RW-2:0], 1'b1};
              end else begin
                rem_d = rem_t[BW-1:0];
                res_d = {res_q[RW-2:0], 1'b0};
              end
            end
          end
        endcase
        if (state_d == S_EXEC) begin
          if (cnt_q == CW'(BW - 1)) state_d = S_B2D;
          else                      cnt_d   = cnt_q + CW'(1);
        end
      end
      S_B2D: begin
        for (int i = 0; i < 2 * DIGITS; i++) begin
          if (adj[4*i +: 4] > 4'd4) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        end
        {bcdw_d, sh_d} = {adj, sh_q} << 1;
        if (cnt_q == CW'(RW - 1)) state_d = S_DONE;
        else                      cnt_d   = cnt_q + CW'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_q == S_EXEC && state_d == S_B2D) begin
      sh_d   = res_d;
      bcdw_d = '0;
      cnt_d  = '0;
    end

    // Visible results change only on the edge that enters DONE.
    if (state_q != S_DONE && state_d == S_DONE) begin
      rbin_d = errw_d ? '0 : res_d;
      rbcd_d = errw_d ? '0 : bcdw_d;
      rneg_d = negw_d;
      rerr_d = errw_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      bcd1_q  <= '0;
      bcd2_q  <= '0;
      sym_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      rem_q   <= '0;
      res_q   <= '0;
      sh_q    <= '0;
      bcdw_q  <= '0;
      cnt_q   <= '0;
      negw_q  <= 1'b0;
      errw_q  <= 1'b0;
      rbin_q  <= '0;
      rbcd_q  <= '0;
      rneg_q  <= 1'b0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd1_q  <= bcd1_d;
      bcd2_q  <= bcd2_d;
      sym_q   <= sym_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      rem_q   <= rem_d;
      res_q   <= res_d;
      sh_q    <= sh_d;
      bcdw_q  <= bcdw_d;
      cnt_q   <= cnt_d;
      negw_q  <= negw_d;
      errw_q  <= errw_d;
      rbin_q  <= rbin_d;
      rbcd_q  <= rbcd_d;
      rneg_q  <= rneg_d;
      rerr_q  <= rerr_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign result_bin = rbin_q;
  assign result_bcd = rbcd_q;
  assign neg        = rneg_q;
  assign err        = rerr_q;

endmodule

// File: tb/tb_bcd_alu_seq.sv
// Bench for bcd_alu_seq: vector table through a scoreboard queue, plus hand sequences for ignored starts and mid-operation reset.
module tb_bcd_alu_seq;

  localparam int DIGITS = 3;
  localparam int BW     = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  sym = 4'h0;
  logic [11:0] num_reg1 = '0;
  logic [11:0] num_reg2 = '0;
  logic        busy, done, neg, err;
  logic [19:0] result_bin;
  logic [23:0] result_bcd;

  bcd_alu_seq #(.DIGITS(DIGITS), .BW(BW)) dut (
    .clk(clk), .rst(rst), .start(start), .sym(sym),
    .num_reg1(num_reg1), .num_reg2(num_reg2),
    .busy(busy), .done(done), .result_bin(result_bin), .result_bcd(result_bcd),
    .neg(neg), .err(err)
  );

  always #5 clk = ~clk;

  int done_cnt = 0;
  always @(negedge clk) if (done) done_cnt++;

  typedef struct {
    logic [3:0]  op;
    logic [11:0] a;
    logic [11:0] b;
    logic [19:0] bin;
    logic [23:0] bcd;
    logic        ng;
    logic        er;
    int          lat;
  } vec_t;

  vec_t vecs[14];
  vec_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic issue(input vec_t v);
    @(negedge clk);
    sym = v.op; num_reg1 = v.a; num_reg2 = v.b; start = 1'b1;
    sb.push_back(v);
    @(posedge clk); #1;
    start = 1'b0; num_reg1 = 12'hFFF; num_reg2 = 12'hFFF; sym = 4'ha;
  endtask

  // Returns the cycle (1 = first cycle after acceptance) in which done was seen; inj>0 pulses a stray start then.
  task automatic wait_done(input int inj, output int lat);
    lat = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (i == 1) chk("busy_after_accept", busy, 1);
      if (inj > 0 && i == inj) begin
        start = 1'b1; sym = 4'hc; num_reg1 = 12'h002; num_reg2 = 12'h003;
      end
      if (inj > 0 && i == inj + 1) start = 1'b0;
      if (done) begin
        lat = i;
        break;
      end
    end
    start = 1'b0;
    if (lat == 0) begin
      n_chk++; n_fail++;
      $display("FAIL done_timeout: actual no done in 200 cycles required done");
    end
  endtask

  task automatic finish_txn(input int lat);
    vec_t e;
    if (sb.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL scoreboard_empty: actual done with no pending request required none");
    end else begin
      e = sb.pop_front();
      chk("latency", lat, e.lat);
      chk("result_bin", result_bin, e.bin);
      chk("result_bcd", result_bcd, e.bcd);
      chk("neg", neg, e.ng);
      chk("err", err, e.er);
    end
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("busy_after_done", busy, 0);
  endtask

  initial begin
    int   lat;
    int   d0;
    vec_t v;

    vecs[0]  = '{4'ha, 12'h123, 12'h456, 20'd579,    24'h000579, 1'b0, 1'b0, 25};
    vecs[1]  = '{4'hb, 12'h045, 12'h100, 20'd55,     24'h000055, 1'b1, 1'b0, 25};
    vecs[2]  = '{4'hb, 12'h100, 12'h100, 20'd0,      24'h000000, 1'b0, 1'b0, 25};
    vecs[3]  = '{4'hc, 12'h999, 12'h999, 20'd998001, 24'h998001, 1'b0, 1'b0, 34};
    vecs[4]  = '{4'hd, 12'h999, 12'h007, 20'd142,    24'h000142, 1'b0, 1'b0, 34};
    vecs[5]  = '{4'hd, 12'h500, 12'h000, 20'd0,      24'h000000, 1'b0, 1'b1, 5};
    vecs[6]  = '{4'ha, 12'h1A3, 12'h001, 20'd0,      24'h000000, 1'b0, 1'b1, 4};
    vecs[7]  = '{4'hb, 12'h789, 12'h012, 20'd777,    24'h000777, 1'b0, 1'b0, 25};
    vecs[8]  = '{4'hc, 12'h012, 12'h034, 20'd408,    24'h000408, 1'b0, 1'b0, 34};
    vecs[9]  = '{4'hd, 12'h100, 12'h003, 20'd33,     24'h000033, 1'b0, 1'b0, 34};
    vecs[10] = '{4'ha, 12'h999, 12'h999, 20'd1998,   24'h001998, 1'b0, 1'b0, 25};
    vecs[11] = '{4'hc, 12'h000, 12'h500, 20'd0,      24'h000000, 1'b0, 1'b0, 34};
    vecs[12] = '{4'hd, 12'h005, 12'h009, 20'd0,      24'h000000, 1'b0, 1'b0, 34};
    vecs[13] = '{4'hb, 12'h000, 12'h999, 20'd999,    24'h000999, 1'b1, 1'b0, 25};

    #2 rst = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result_bin", result_bin, 0);
    chk("rst_result_bcd", result_bcd, 0);
    chk("rst_neg", neg, 0);
    chk("rst_err", err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 14; i++) begin
      issue(vecs[i]);
      wait_done(0, lat);
      finish_txn(lat);
    end

    repeat (3) @(negedge clk);
    chk("hold_result_bin", result_bin, 20'd999);
    chk("hold_neg", neg, 1);

    // Unsupported operator must not start anything.
    d0 = done_cnt;
    @(negedge clk);
    sym = 4'he; num_reg1 = 12'h123; num_reg2 = 12'h001; start = 1'b1;
    @(negedge clk);
    chk("bad_sym_busy", busy, 0);
    start = 1'b0;
    repeat (30) @(negedge clk);
    chk("bad_sym_no_done", done_cnt, d0);
    chk("bad_sym_result_kept", result_bin, 20'd999);

    // Stray start while busy: one done, first operation's result.
    v = '{4'ha, 12'h321, 12'h111, 20'd432, 24'h000432, 1'b0, 1'b0, 25};
    issue(v);
    wait_done(5, lat);
    finish_txn(lat);
    d0 = done_cnt;
    repeat (40) @(negedge clk);
    chk("busy_start_extra_done", done_cnt, d0);
    chk("busy_start_idle", busy, 0);

    // Start held only during the done cycle is ignored.
    v = '{4'ha, 12'h001, 12'h002, 20'd3, 24'h000003, 1'b0, 1'b0, 25};
    issue(v);
    wait_done(0, lat);
    sym = 4'ha; num_reg1 = 12'h111; num_reg2 = 12'h111; start = 1'b1;
    finish_txn(lat);
    start = 1'b0;
    d0 = done_cnt;
    repeat (30) @(negedge clk);
    chk("done_cycle_start_ignored", done_cnt, d0);
    chk("done_cycle_result", result_bin, 20'd3);

    // Reset in the middle of a multiply.
    issue(vecs[3]);
    repeat (9) @(negedge clk);
    chk("mid_mul_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result_bin", result_bin, 0);
    chk("abort_result_bcd", result_bcd, 0);
    chk("abort_neg", neg, 0);
    chk("abort_err", err, 0);
    sb.delete();
    d0 = done_cnt;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_no_done", done_cnt, d0);
    issue(vecs[0]);
    wait_done(0, lat);
    finish_txn(lat);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
